// File: rtl/control_unit_ps.sv
// Control sequencer: fetch/decode/execute/ALU/writeback with CALL/RETURN stack tracking,
// I/O wait states and a maskable interrupt entry. Outputs are registered as the state is entered.
module control_unit_ps #(
  parameter int OP_W        = 6,
  parameter int ALU_OP_W    = 4,
  parameter int STACK_DEPTH = 8,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     op_code,
  input  logic                carry,
  input  logic                zero,
  input  logic                io_ready,
  input  logic                int_req,
  output logic                instruction_en,
  output logic                pc_en,
  output logic                alu_en,
  output logic                rf_write_en,
  output logic                rf_read_en,
  output logic                io_write_en,
  output logic                io_read_en,
  output logic                pc_jump,
  output logic [1:0]          pc_src,
  output logic                stack_push,
  output logic                stack_pop,
  output logic [SP_W-1:0]     sp,
  output logic                stack_err,
  output logic                int_ack,
  output logic [ALU_OP_W-1:0] alu_operate,
  output logic                alu_operand_sel,
  output logic [1:0]          rf_w_data_src
);

  localparam logic [OP_W-1:0] OP_JUMP    = OP_W'(6'b100010);
  localparam logic [OP_W-1:0] OP_JUMPC   = OP_W'(6'b111010);
  localparam logic [OP_W-1:0] OP_JUMPZ   = OP_W'(6'b110010);
  localparam logic [OP_W-1:0] OP_INPUT   = OP_W'(6'b001001);
  localparam logic [OP_W-1:0] OP_OUTPUT  = OP_W'(6'b101101);
  localparam logic [OP_W-1:0] OP_LOADI   = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] OP_LOADR   = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI    = OP_W'(6'b010001);
  localparam logic [OP_W-1:0] OP_ADDR    = OP_W'(6'b010000);
  localparam logic [OP_W-1:0] OP_COMPARE = OP_W'(6'b011101);
  localparam logic [OP_W-1:0] OP_SUB     = OP_W'(6'b011001);
  localparam logic [OP_W-1:0] OP_CALL    = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] OP_RETURN  = OP_W'(6'b100101);
  localparam logic [OP_W-1:0] OP_RETI    = OP_W'(6'b101001);
  localparam logic [OP_W-1:0] OP_ENINT   = OP_W'(6'b111100);
  localparam logic [OP_W-1:0] OP_DISINT  = OP_W'(6'b111101);

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXECUTE, S_IO_WAIT, S_ALU, S_WBACK, S_INT_ACK
  } state_t;

  state_t          state;
  logic            ie;
  logic            int_take;
  logic [SP_W-1:0] sp_after;
  logic            fetch_int;
  logic            sp_full;
  logic            sp_empty;

  // Occupancy once the strobes of the current cycle retire; the interrupt decision is
  // taken on entry to FETCH, so it must see the stack as it will be during FETCH.
  assign sp_after  = sp + SP_W'(stack_push) - SP_W'(stack_pop);
  assign fetch_int = int_req & ie & (sp_after < SP_W'(STACK_DEPTH));
  assign sp_full   = (sp == SP_W'(STACK_DEPTH));
  assign sp_empty  = (sp == '0);

  assign alu_operate     = (op_code == OP_ADDI || op_code == OP_ADDR) ? '0 : ALU_OP_W'(1);
  assign alu_operand_sel = (op_code == OP_ADDI || op_code == OP_SUB || op_code == OP_COMPARE);

  always_comb begin
    rf_w_data_src = 2'b11;
    if (op_code == OP_INPUT)      rf_w_data_src = 2'b00;
    else if (op_code == OP_LOADI) rf_w_data_src = 2'b01;
    else if (op_code == OP_LOADR) rf_w_data_src = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_RESET;
      instruction_en <= 1'b0;
      pc_en          <= 1'b0;
      alu_en         <= 1'b0;
      rf_write_en    <= 1'b0;
      rf_read_en     <= 1'b0;
      io_write_en    <= 1'b0;
      io_read_en     <= 1'b0;
      pc_jump        <= 1'b0;
      pc_src         <= 2'b00;
      stack_push     <= 1'b0;
      stack_pop      <= 1'b0;
      int_ack        <= 1'b0;
      int_take       <= 1'b0;
      sp             <= '0;
      stack_err      <= 1'b0;
      ie             <= 1'b0;
    end else begin
      instruction_en <= 1'b0;
      pc_en          <= 1'b0;
      alu_en         <= 1'b0;
      rf_write_en    <= 1'b0;
      rf_read_en     <= 1'b0;
      io_write_en    <= 1'b0;
      io_read_en     <= 1'b0;
      pc_jump        <= 1'b0;
      pc_src         <= 2'b00;
      stack_push     <= 1'b0;
      stack_pop      <= 1'b0;
      int_ack        <= 1'b0;
      int_take       <= 1'b0;
      sp             <= sp_after;
      case (state)
        S_FETCH: begin
          if (int_take) begin
            state      <= S_INT_ACK;
            int_ack    <= 1'b1;
            stack_push <= 1'b1;
            pc_src     <= 2'b10;
            pc_en      <= 1'b1;
            ie         <= 1'b0;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_EXECUTE;
          pc_en <= 1'b1;
          case (op_code)
            OP_LOADR, OP_OUTPUT, OP_ADDI, OP_ADDR, OP_SUB, OP_COMPARE: rf_read_en <= 1'b1;
            OP_LOADI: rf_write_en <= 1'b1;
            OP_JUMP:  pc_jump <= 1'b1;
            OP_JUMPC: pc_jump <= carry;
            OP_JUMPZ: pc_jump <= zero;
            OP_CALL: begin
              if (!sp_full) begin
                stack_push <= 1'b1;
                pc_jump    <= 1'b1;
              end else begin
                stack_err <= 1'b1;
              end
            end
            OP_RETURN, OP_RETI: begin
              if (!sp_empty) begin
                stack_pop <= 1'b1;
                pc_src    <= 2'b01;
                if (op_code == OP_RETI) ie <= 1'b1;
              end else begin
                stack_err <= 1'b1;
              end
            end
            OP_ENINT:  ie <= 1'b1;
            OP_DISINT: ie <= 1'b0;
            default: ;
          endcase
        end
        S_EXECUTE: begin
          case (op_code)
            OP_INPUT: begin
              state      <= S_IO_WAIT;
              io_read_en <= 1'b1;
            end
            OP_OUTPUT: begin
              state       <= S_IO_WAIT;
              io_write_en <= 1'b1;
            end
            OP_LOADR: begin
              state       <= S_WBACK;
              rf_write_en <= 1'b1;
            end
            OP_ADDI, OP_ADDR, OP_SUB, OP_COMPARE: begin
              state  <= S_ALU;
              alu_en <= 1'b1;
            end
            default: begin
              state          <= S_FETCH;
              int_take       <= fetch_int;
              instruction_en <= ~fetch_int;
            end
          endcase
        end
        S_IO_WAIT: begin
          if (!io_ready) begin
            state       <= S_IO_WAIT;
            io_read_en  <= io_read_en;
            io_write_en <= io_write_en;
          end else if (io_read_en) begin
            state       <= S_WBACK;
            rf_write_en <= 1'b1;
          end else begin
            state          <= S_FETCH;
            int_take       <= fetch_int;
            instruction_en <= ~fetch_int;
          end
        end
        S_ALU: begin
          if (op_code == OP_COMPARE) begin
            state          <= S_FETCH;
            int_take       <= fetch_int;
            instruction_en <= ~fetch_int;
          end else begin
            state       <= S_WBACK;
            rf_write_en <= 1'b1;
          end
        end
        S_RESET, S_WBACK, S_INT_ACK: begin
          state          <= S_FETCH;
          int_take       <= fetch_int;
          instruction_en <= ~fetch_int;
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule
